// File: rtl/led_frame_scheduler_if.sv
// Pixel stream between the frame scheduler and the WS2811 bit serializer.
// A pixel transfers on any cycle where pixel_valid and pixel_ready are both high.
interface led_frame_scheduler_if;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (
        output pixel_data,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Steps ledindex across the LED string and waits for the colour pipeline to settle on each pixel.
// It buffers one {r,g,b} pixel toward the serializer, then holds the latch gap between frames.
module led_frame_scheduler #(
    parameter int NUM_LEDS      = 50,
    parameter int SETTLE_CYCLES = 64,
    parameter int LATCH_CYCLES  = 600
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [7:0]                   red,
    input  logic [7:0]                   green,
    input  logic [7:0]                   blue,
    output logic [7:0]                   ledindex,
    led_frame_scheduler_if.master        pix,
    output logic                         latch_active,
    output logic                         frame_start,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int CNT_W   = $clog2(SETTLE_CYCLES);
    localparam int LATCH_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]         LED_LAST  = 8'(NUM_LEDS - 1);
    localparam logic [LATCH_W-1:0] LATCH_END = LATCH_W'(LATCH_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DRAIN,
        LATCH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [LATCH_W-1:0] latch_cnt;

    logic transfer;
    logic buf_free;
    logic at_settle;
    logic last_led;
    logic latch_end;
    logic capture;
    logic start_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The buffer may be refilled on the same cycle its current pixel is accepted.
    always_comb begin
        state_next   = state;
        transfer     = pix.pixel_valid & pix.pixel_ready;
        buf_free     = !pix.pixel_valid || transfer;
        at_settle    = (cnt == CNT_LAST);
        last_led     = (ledindex == LED_LAST);
        latch_end    = (latch_cnt == LATCH_END);
        capture      = (state == COMPUTE) && at_settle && buf_free;
        busy         = (state != IDLE);
        latch_active = (state == LATCH) && !latch_end;
        frame_done   = (state == LATCH) && latch_end;
        frame_start  = (state == COMPUTE) && (cnt == '0) && (ledindex == 8'd0);

        case (state)
            IDLE: begin
                if (enable) state_next = COMPUTE;
            end
            COMPUTE: begin
                if (capture && last_led) state_next = DRAIN;
            end
            DRAIN: begin
                if (buf_free) state_next = LATCH;
            end
            LATCH: begin
                if (latch_end) state_next = enable ? COMPUTE : IDLE;
            end
            default: state_next = IDLE;
        endcase

        start_frame = (state != COMPUTE) && (state_next == COMPUTE);
    end

    // cnt parks on its last value while the buffer is still full, so the capture fires on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix.pixel_data  <= '0;
            pix.pixel_valid <= 1'b0;
            cnt             <= '0;
            ledindex        <= 8'd0;
            latch_cnt       <= '0;
        end else begin
            if (capture) begin
                pix.pixel_data  <= {red, green, blue};
                pix.pixel_valid <= 1'b1;
            end else if (transfer) begin
                pix.pixel_valid <= 1'b0;
            end

            if (state == COMPUTE) begin
                if (capture) begin
                    cnt <= '0;
                end else if (!at_settle) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            if (start_frame) begin
                ledindex <= 8'd0;
            end else if (capture && !last_led) begin
                ledindex <= ledindex + 8'd1;
            end

            if ((state == LATCH) && !latch_end) begin
                latch_cnt <= latch_cnt + 1'b1;
            end else begin
                latch_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: one 3-pixel string and one 1-pixel string,
// both with a pipeline that returns {ledindex, ~ledindex, 8'h5A}.
module tb_led_frame_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic ready = 1'b1;

    logic [7:0] li3, li1;
    logic       latch3, start3, done3, busy3;
    logic       latch1, start1, done1, busy1;

    led_frame_scheduler_if bus3 ();
    led_frame_scheduler_if bus1 ();

    assign bus3.pixel_ready = ready;
    assign bus1.pixel_ready = ready;

    led_frame_scheduler #(.NUM_LEDS(3), .SETTLE_CYCLES(64), .LATCH_CYCLES(100)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .red          (li3),
        .green        (~li3),
        .blue         (8'h5A),
        .ledindex     (li3),
        .pix          (bus3),
        .latch_active (latch3),
        .frame_start  (start3),
        .frame_done   (done3),
        .busy         (busy3)
    );

    led_frame_scheduler #(.NUM_LEDS(1), .SETTLE_CYCLES(64), .LATCH_CYCLES(20)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .red          (li1),
        .green        (~li1),
        .blue         (8'h5A),
        .ledindex     (li1),
        .pix          (bus1),
        .latch_active (latch1),
        .frame_start  (start1),
        .frame_done   (done1),
        .busy         (busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        bit          sel;
        bit          ready;
        bit          enable;
        logic        valid;
        logic [23:0] data;
        logic [7:0]  li;
        bit          chk_li;
        logic        start;
        logic        latch;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   k = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic step_to(input int t);
        while (k < t) step(1);
    endtask

    task automatic apply_stimulus(input bit r, input bit e, input bit rd);
        rst    = r;
        enable = e;
        ready  = rd;
    endtask

    task automatic start_run();
        apply_stimulus(1'b1, 1'b0, 1'b1);
        step(2);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        k = 0;
    endtask

    task automatic check_output(input string name, input bit sel, input logic valid,
                                input logic [23:0] data, input logic [7:0] li, input bit chk_li,
                                input logic start, input logic latch, input logic done,
                                input logic busy);
        logic [36:0] act, exp;
        if (sel) act = {bus1.pixel_valid, bus1.pixel_data, li1, start1, latch1, done1, busy1};
        else     act = {bus3.pixel_valid, bus3.pixel_data, li3, start3, latch3, done3, busy3};
        exp = {valid, data, li, start, latch, done, busy};
        if (!chk_li) begin
            act[11:4] = 8'h00;
            exp[11:4] = 8'h00;
        end
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s (k=%0d dut%0d): got v=%b d=%06h li=%02h s/l/d/b=%b%b%b%b, expected v=%b d=%06h li=%02h s/l/d/b=%b%b%b%b",
                     name, k, sel ? 1 : 3, act[36], act[35:12], act[11:4], act[3], act[2], act[1], act[0],
                     exp[36], exp[35:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int kk, input bit sel, input logic v, input logic [23:0] d,
                                input logic [7:0] li, input logic s, input logic l,
                                input logic dn, input logic b);
        vec_t r;
        r.k = kk;  r.sel = sel;  r.ready = 1'b1;  r.enable = 1'b1;
        r.valid = v;  r.data = d;  r.li = li;  r.chk_li = 1'b1;
        r.start = s;  r.latch = l;  r.done = dn;  r.busy = b;
        return r;
    endfunction

    initial begin
        int gaps;
        int starts;

        // Free-running frames with the serializer always ready, both string lengths side by side.
        vecs.push_back(mk(  1, 0, 0, 24'h000000, 8'd0, 1, 0, 0, 1));
        vecs.push_back(mk(  1, 1, 0, 24'h000000, 8'd0, 1, 0, 0, 1));
        vecs.push_back(mk(  2, 0, 0, 24'h000000, 8'd0, 0, 0, 0, 1));
        vecs.push_back(mk( 64, 0, 0, 24'h000000, 8'd0, 0, 0, 0, 1));
        vecs.push_back(mk( 65, 0, 1, 24'h00FF5A, 8'd1, 0, 0, 0, 1));
        vecs.push_back(mk( 65, 1, 1, 24'h00FF5A, 8'd0, 0, 0, 0, 1));
        vecs.push_back(mk( 66, 0, 0, 24'h00FF5A, 8'd1, 0, 0, 0, 1));
        vecs.push_back(mk( 66, 1, 0, 24'h00FF5A, 8'd0, 0, 1, 0, 1));
        vecs.push_back(mk( 85, 1, 0, 24'h00FF5A, 8'd0, 0, 1, 0, 1));
        vecs.push_back(mk( 86, 1, 0, 24'h00FF5A, 8'd0, 0, 0, 1, 1));
        vecs.push_back(mk( 87, 1, 0, 24'h00FF5A, 8'd0, 1, 0, 0, 1));
        vecs.push_back(mk(100, 1, 0, 24'h00FF5A, 8'd0, 0, 0, 0, 1));
        vecs.push_back(mk(128, 0, 0, 24'h00FF5A, 8'd1, 0, 0, 0, 1));
        vecs.push_back(mk(129, 0, 1, 24'h01FE5A, 8'd2, 0, 0, 0, 1));
        vecs.push_back(mk(130, 0, 0, 24'h01FE5A, 8'd2, 0, 0, 0, 1));
        vecs.push_back(mk(151, 1, 1, 24'h00FF5A, 8'd0, 0, 0, 0, 1));
        vecs.push_back(mk(152, 1, 0, 24'h00FF5A, 8'd0, 0, 1, 0, 1));
        vecs.push_back(mk(192, 0, 0, 24'h01FE5A, 8'd2, 0, 0, 0, 1));
        vecs.push_back(mk(193, 0, 1, 24'h02FD5A, 8'd2, 0, 0, 0, 1));
        vecs.push_back(mk(194, 0, 0, 24'h02FD5A, 8'd2, 0, 1, 0, 1));
        vecs.push_back(mk(293, 0, 0, 24'h02FD5A, 8'd2, 0, 1, 0, 1));
        vecs.push_back(mk(294, 0, 0, 24'h02FD5A, 8'd2, 0, 0, 1, 1));
        vecs.push_back(mk(295, 0, 0, 24'h02FD5A, 8'd0, 1, 0, 0, 1));

        apply_stimulus(1'b1, 1'b0, 1'b1);
        step(2);
        check_output("reset3", 0, 0, 24'h0, 8'd0, 1, 0, 0, 0, 0);
        check_output("reset1", 1, 0, 24'h0, 8'd0, 1, 0, 0, 0, 0);

        start_run();
        for (int i = 0; i < vecs.size(); i++) begin
            step_to(vecs[i].k);
            check_output($sformatf("vec%0d", i), vecs[i].sel, vecs[i].valid, vecs[i].data,
                         vecs[i].li, vecs[i].chk_li, vecs[i].start, vecs[i].latch,
                         vecs[i].done, vecs[i].busy);
            apply_stimulus(1'b0, vecs[i].enable, vecs[i].ready);
        end

        // Serializer stalls for 200 cycles with pixel 0 pending.
        start_run();
        step_to(64);
        ready = 1'b0;
        step_to(65);
        check_output("stall_p0", 0, 1, 24'h00FF5A, 8'd1, 1, 0, 0, 0, 1);
        step_to(128);
        check_output("stall_mid", 0, 1, 24'h00FF5A, 8'd1, 1, 0, 0, 0, 1);
        step_to(265);
        check_output("stall_end", 0, 1, 24'h00FF5A, 8'd1, 1, 0, 0, 0, 1);
        ready = 1'b1;
        step_to(266);
        check_output("stall_rel", 0, 1, 24'h01FE5A, 8'd2, 1, 0, 0, 0, 1);
        step_to(267);
        check_output("stall_p1x", 0, 0, 24'h01FE5A, 8'd2, 1, 0, 0, 0, 1);
        step_to(330);
        check_output("stall_p2", 0, 1, 24'h02FD5A, 8'd2, 1, 0, 0, 0, 1);
        step_to(331);
        check_output("stall_latch", 0, 0, 24'h02FD5A, 8'd2, 1, 0, 1, 0, 1);

        // Ready arrives exactly on the pixel 1 capture cycle: valid never drops.
        start_run();
        step_to(64);
        ready = 1'b0;
        gaps = 0;
        while (k < 128) begin
            step(1);
            if (bus3.pixel_valid !== 1'b1) gaps++;
        end
        ready = 1'b1;
        step_to(129);
        if (bus3.pixel_valid !== 1'b1) gaps++;
        check_int("b2b_gaps", gaps, 0);
        check_output("b2b_p1", 0, 1, 24'h01FE5A, 8'd2, 1, 0, 0, 0, 1);
        step_to(130);
        check_output("b2b_p1x", 0, 0, 24'h01FE5A, 8'd2, 1, 0, 0, 0, 1);

        // enable dropped during pixel 1: the frame finishes, then the block idles.
        start_run();
        step_to(100);
        check_output("en_mid", 0, 0, 24'h00FF5A, 8'd1, 1, 0, 0, 0, 1);
        enable = 1'b0;
        step_to(129);
        check_output("en_p1", 0, 1, 24'h01FE5A, 8'd2, 1, 0, 0, 0, 1);
        step_to(193);
        check_output("en_p2", 0, 1, 24'h02FD5A, 8'd2, 1, 0, 0, 0, 1);
        step_to(194);
        check_output("en_latch", 0, 0, 24'h02FD5A, 8'd2, 1, 0, 1, 0, 1);
        step_to(294);
        check_output("en_done", 0, 0, 24'h02FD5A, 8'd2, 1, 0, 0, 1, 1);
        step_to(295);
        check_output("en_idle", 0, 0, 24'h02FD5A, 8'd0, 0, 0, 0, 0, 0);
        starts = 0;
        while (k < 400) begin
            step(1);
            if (start3 !== 1'b0) starts++;
        end
        check_int("en_no_start", starts, 0);
        check_output("en_idle2", 0, 0, 24'h02FD5A, 8'd0, 0, 0, 0, 0, 0);

        // Reset during the latch gap.
        start_run();
        step_to(250);
        check_output("rl_pre", 0, 0, 24'h02FD5A, 8'd2, 1, 0, 1, 0, 1);
        rst = 1'b1;
        step_to(251);
        check_output("rl_reset", 0, 0, 24'h000000, 8'd0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        step_to(252);
        check_output("rl_restart", 0, 0, 24'h000000, 8'd0, 1, 1, 0, 0, 1);

        // Reset while a pixel is pending in the buffer.
        start_run();
        step_to(64);
        ready = 1'b0;
        step_to(100);
        check_output("rv_pre", 0, 1, 24'h00FF5A, 8'd1, 1, 0, 0, 0, 1);
        rst = 1'b1;
        step_to(101);
        check_output("rv_reset", 0, 0, 24'h000000, 8'd0, 1, 0, 0, 0, 0);
        rst   = 1'b0;
        ready = 1'b1;
        step_to(102);
        check_output("rv_restart", 0, 0, 24'h000000, 8'd0, 1, 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
